// File: rtl/rx_clk_pkg.sv
// rx_clk_pkg: shared types and widths for the RX DCM lock controller.
//   Contents: lock-sequencer state enum (3-bit), timer/retry/loss-counter widths.
package rx_clk_pkg;
   typedef enum logic [2:0] {
      RST_DCM   = 3'd0,
      WAIT_LOCK = 3'd1,
      SETTLE    = 3'd2,
      RUN       = 3'd3,
      FAIL      = 3'd4
   } rx_clk_state_t;
   localparam int TIMER_W = 16;
   localparam int RETRY_W = 4;
   localparam int LOSS_W  = 8;
endpackage

// File: rtl/rx_sync2.sv
// rx_sync2: generic 2-flop synchroniser, synchronous active-high reset to 0.
//   Ports: clk (in), rst (in), d (in, W, asynchronous), q (out, W, 2-cycle latency).
module rx_sync2 #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   logic [W-1:0] r_meta;
   logic [W-1:0] r_sync;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_meta <= '0;
         r_sync <= '0;
      end else begin
         r_meta <= d;
         r_sync <= r_meta;
      end
   end
   assign q = r_sync;
endmodule

// File: rtl/rx_dcm_lock_ctrl.sv
// rx_dcm_lock_ctrl: sequences the RX DCM reset, waits for lock with timeout/retry,
//   debounces lock and only then releases the RX datapath reset; re-runs on loss of lock.
//   Ports: rxclk, reset (sync, active high), dcm_locked (async) in;
//          dcm_rst, rx_rst, clk_ready, lock_fail, retry_cnt[3:0], lock_loss_cnt[7:0] out.
//   Option: define RX_DCM_LOSS_CNT_EN to count RUN lock losses (saturating); otherwise tied to 0.
module rx_dcm_lock_ctrl
   import rx_clk_pkg::*;
#(
   parameter int RST_CYCLES    = 8,
   parameter int LOCK_TIMEOUT  = 16384,
   parameter int SETTLE_CYCLES = 64,
   parameter int MAX_RETRY     = 4
) (
   input  logic               rxclk,
   input  logic               reset,
   input  logic               dcm_locked,
   output logic               dcm_rst,
   output logic               rx_rst,
   output logic               clk_ready,
   output logic               lock_fail,
   output logic [RETRY_W-1:0] retry_cnt,
   output logic [LOSS_W-1:0]  lock_loss_cnt
);
   localparam logic [TIMER_W-1:0] L_RST_LAST = TIMER_W'(RST_CYCLES - 1);
   localparam logic [TIMER_W-1:0] L_TO_LAST  = TIMER_W'(LOCK_TIMEOUT - 1);
   localparam logic [TIMER_W-1:0] L_SET_LAST = TIMER_W'(SETTLE_CYCLES - 1);
   localparam logic [RETRY_W-1:0] L_RETRY_LAST = RETRY_W'(MAX_RETRY - 1);
   rx_clk_state_t      r_state, w_state_nx;
   logic [TIMER_W-1:0] r_timer, w_timer_nx;
   logic [RETRY_W-1:0] r_retry, w_retry_nx;
   logic               w_locked_s;
   rx_sync2 #(.W(1)) u_sync (
      .clk (rxclk),
      .rst (reset),
      .d   (dcm_locked),
      .q   (w_locked_s)
   );
   // Every transition clears the timer, so it never needs to wrap.
   always_comb begin
      w_state_nx = r_state;
      w_timer_nx = r_timer + 1'b1;
      w_retry_nx = r_retry;
      case (r_state)
         RST_DCM: begin
            if (r_timer == L_RST_LAST) begin
               w_state_nx = WAIT_LOCK;
               w_timer_nx = '0;
            end
         end
         WAIT_LOCK: begin
            // Lock takes priority over a coincident timeout.
            if (w_locked_s) begin
               w_state_nx = SETTLE;
               w_timer_nx = '0;
            end else if (r_timer == L_TO_LAST) begin
               w_timer_nx = '0;
               if (r_retry == L_RETRY_LAST) begin
                  w_state_nx = FAIL;
               end else begin
                  w_state_nx = RST_DCM;
                  w_retry_nx = r_retry + 1'b1;
               end
            end
         end
         SETTLE: begin
            // A glitch restarts the lock wait without spending a retry.
            if (!w_locked_s) begin
               w_state_nx = WAIT_LOCK;
               w_timer_nx = '0;
            end else if (r_timer == L_SET_LAST) begin
               w_state_nx = RUN;
               w_timer_nx = '0;
               w_retry_nx = '0;
            end
         end
         RUN: begin
            w_timer_nx = '0;
            if (!w_locked_s) w_state_nx = RST_DCM;
         end
         FAIL: w_timer_nx = '0;
         default: begin
            w_state_nx = RST_DCM;
            w_timer_nx = '0;
         end
      endcase
   end
   always_ff @(posedge rxclk) begin
      if (reset) begin
         r_state <= RST_DCM;
         r_timer <= '0;
         r_retry <= '0;
      end else begin
         r_state <= w_state_nx;
         r_timer <= w_timer_nx;
         r_retry <= w_retry_nx;
      end
   end
`ifdef RX_DCM_LOSS_CNT_EN
   logic [LOSS_W-1:0] r_loss;
   always_ff @(posedge rxclk) begin
      if (reset) r_loss <= '0;
      else if (r_state == RUN && !w_locked_s && r_loss != '1) r_loss <= r_loss + 1'b1;
   end
   assign lock_loss_cnt = r_loss;
`else
   assign lock_loss_cnt = '0;
`endif
   assign dcm_rst   = (r_state == RST_DCM) || (r_state == FAIL);
   assign rx_rst    = (r_state != RUN);
   assign clk_ready = (r_state == RUN);
   assign lock_fail = (r_state == FAIL);
   assign retry_cnt = r_retry;
endmodule
